serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
//
// PURPOSE
// Bit-serial addition sequencer built around the single-bit full_adder datapath.
// Takes two WIDTH-bit operands plus carry-in. Feeds them LSB-first through one
// external full adder, one bit per clock, recirculating the carry in a register.
// Returns a WIDTH-bit sum and carry-out, using a start/busy/done handshake.
//
// PARAMETERS
// WIDTH  8  operand/sum width in bits; legal range >= 1
//
// PORTS
// clk       in   1      system clock, rising edge
// rst_n     in   1      asynchronous active-low reset
// start     in   1      request; sampled only in IDLE
// a_in      in   WIDTH  operand A, captured on the accepted start
// b_in      in   WIDTH  operand B, captured on the accepted start
// cin_in    in   1      carry-in, captured on the accepted start
// busy      out  1      1 while in RUN
// done      out  1      1-cycle pulse: sum_out/cout_out just updated
// sum_out   out  WIDTH  result register; holds until next completion
// cout_out  out  1      final carry register; holds until next completion
// fa_a      out  1      to full adder A input
// fa_b      out  1      to full adder B input
// fa_cin    out  1      to full adder Cin input
// fa_sum    in   1      from full adder Sum; combinational, same cycle
// fa_cout   in   1      from full adder Cout; combinational, same cycle
//
// BEHAVIOUR
// - Reset, async on rst_n=0:
//   - state=IDLE.
//   - busy, done, sum_out, cout_out, fa_a, fa_b, fa_cin all 0.
//   - Shift registers, carry register and bit counter are cleared.
// - FSM states: IDLE, RUN, DONE.
// - IDLE:
//   - On start=1: load a_sr<=a_in, b_sr<=b_in, carry<=cin_in, cnt<=0; go to RUN.
//   - Otherwise stay in IDLE.
// - RUN (busy=1):
//   - Combinational drive: fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry.
//   - Each edge:
//     - Shift a_sr and b_sr right by one.
//     - s_sr <= {fa_sum, s_sr[WIDTH-1:1]}.
//     - carry <= fa_cout.
//     - cnt++.
//   - When cnt==WIDTH-1 at the edge: load sum_out <= {fa_sum, s_sr[WIDTH-1:1]}
//     and cout_out <= fa_cout, then go to DONE.
// - DONE: done=1 for exactly one cycle, busy=0; return unconditionally to IDLE.
// - Outside RUN: fa_a, fa_b and fa_cin are driven 0.
// - Latency: the edge that samples start is edge 0. done is high in the cycle
//   after edge WIDTH. Next start is accepted at the earliest 2 cycles after
//   done falls... no: it is accepted at the first IDLE cycle, i.e. the cycle
//   immediately after done.
// - start while in RUN or DONE: ignored, not queued. Operand inputs are don't-care.
// - sum_out/cout_out are unchanged during RUN; they update only on entry to DONE.
// - Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, computed modulo 2^(WIDTH+1).
// - WIDTH=1: RUN lasts exactly one cycle.
// - Reset mid-RUN: aborts immediately. No done pulse; sum_out/cout_out are cleared to 0.
// - cnt width: $clog2(WIDTH)+1 bits, so that WIDTH=1 is legal.
//
// TESTING
// Bench connects a combinational full-adder model to the fa_* ports.
// 1. WIDTH=8: a=0x5A, b=0x3C, cin=0.
//    -> sum_out=0x96, cout_out=0; done 8 edges after start; busy high 8 cycles.
// 2. WIDTH=8: a=0xFF, b=0x01, cin=0.
//    -> sum_out=0x00, cout_out=1 (full carry ripple).
// 3. WIDTH=8: a=0xFF, b=0xFF, cin=1.
//    -> sum_out=0xFF, cout_out=1.
// 4. Pulse start again at RUN cycle 3 with different operands.
//    -> ignored; result is from the first operands; exactly one done pulse.
// 5. rst_n low at RUN cycle 4.
//    -> all outputs 0 immediately; no done.
//    Then a=0x01, b=0x02 -> sum_out=0x03, cout_out=0.
// 6. WIDTH=1: sweep all 8 {a,b,cin} combos, back-to-back.
//    -> {cout_out,sum_out} = a+b+cin each time; done 1 edge after each start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial adder sequencer; drives one external full adder LSB-first.
// Latency : start sampled on edge 0, done high in the cycle after edge WIDTH.
// Backpr. : start is only honoured in IDLE; starts during RUN/DONE are dropped.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, a_in, b_in, cin_in  request and operands, captured on an accepted start
//   busy, done                 busy while RUN; done pulses one cycle with new result
//   sum_out, cout_out          result registers, held until the next completion
//   fa_a, fa_b, fa_cin         to the external full adder (0 outside RUN)
//   fa_sum, fa_cout            combinational results back from the full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  // One extra counter bit keeps the counter non-zero-width when WIDTH=1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] s_next;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the sum
  // has walked down to position 0.
  assign s_next = WIDTH'({fa_sum, s_sr_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_next;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the full result directly, including this bit.
          sum_d   = s_next;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

  // The full adder sees the current LSBs and carry only while running.
  assign fa_a   = (state_q == ST_RUN) & a_sr_q[0];
  assign fa_b   = (state_q == ST_RUN) & b_sr_q[0];
  assign fa_cin = (state_q == ST_RUN) & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Purpose : exercises serial_add_ctrl at WIDTH=8 and WIDTH=1 with a full-adder model.
// Latency : expects done exactly WIDTH edges after the edge that accepts start.
// Backpr. : checks that starts during RUN are dropped and reset aborts a run.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       fa8_a, fa8_b, fa8_cin, fa8_sum, fa8_cout;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic       fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_cout;

  // Combinational full adders
  assign fa8_sum  = fa8_a ^ fa8_b ^ fa8_cin;
  assign fa8_cout = (fa8_a & fa8_b) | (fa8_a & fa8_cin) | (fa8_b & fa8_cin);
  assign fa1_sum  = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_cout = (fa1_a & fa1_b) | (fa1_a & fa1_cin) | (fa1_b & fa1_cin);

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a_in(a8), .b_in(b8), .cin_in(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_cin(fa8_cin),
    .fa_sum(fa8_sum), .fa_cout(fa8_cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_in(a1), .b_in(b1), .cin_in(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin),
    .fa_sum(fa1_sum), .fa_cout(fa1_cout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    string      name;
  } vec_t;

  // One 8-bit transaction. j counts negedges after the accepting edge, so
  // done belongs at j=8. If inj_j>=0 a conflicting start is pulsed at RUN cycle inj_j.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input string nm, input int inj_j);
    logic [7:0] prev_s;
    logic       prev_c;
    int         busy_n, done_n, done_at;
    logic       hold_ok;
    @(negedge clk);
    prev_s = sum8;
    prev_c = cout8;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    busy_n = 0; done_n = 0; done_at = -1; hold_ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk({nm, " fa_a bit0"}, fa8_a, a[0]);
        chk({nm, " fa_b bit0"}, fa8_b, b[0]);
        chk({nm, " fa_cin"}, fa8_cin, c);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (done_at < 0 && (sum8 !== prev_s || cout8 !== prev_c)) hold_ok = 1'b0;
      if (inj_j >= 0 && j == inj_j) begin
        start8 = 1'b1; a8 = ~a; b8 = a; cin8 = ~c;
      end
      if (inj_j >= 0 && j == inj_j + 1) start8 = 1'b0;
    end
    chk({nm, " done latency"}, done_at, 8);
    chk({nm, " done pulses"}, done_n, 1);
    chk({nm, " busy cycles"}, busy_n, 8);
    chk({nm, " result held in RUN"}, hold_ok, 1'b1);
    chk({nm, " sum_out"}, sum8, es);
    chk({nm, " cout_out"}, cout8, ec);
  endtask

  initial begin
    vec_t        vecs[3];
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  rexp;
    logic [2:0]  v;
    logic [1:0]  e1;
    int          stray;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1_basic"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2_ripple"};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3_all_ones"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy8", busy8, 0);
    chk("rst done8", done8, 0);
    chk("rst sum8", sum8, 0);
    chk("rst cout8", cout8, 0);
    chk("rst fa8", {fa8_a, fa8_b, fa8_cin}, 0);
    chk("rst w1 outputs", {busy1, done1, sum1, cout1, fa1_a, fa1_b, fa1_cin}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy8", busy8, 0);

    // Directed vectors
    for (int i = 0; i < 3; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].name, -1);

    // Start during RUN is ignored
    op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "t4_ignored_start", 3);

    // Reset mid-RUN
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    chk("t5 busy before reset", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 busy after reset", busy8, 0);
    chk("t5 done after reset", done8, 0);
    chk("t5 sum cleared", sum8, 0);
    chk("t5 cout cleared", cout8, 0);
    chk("t5 fa cleared", {fa8_a, fa8_b, fa8_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done8 || busy8) stray++;
    end
    chk("t5 no done after abort", stray, 0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t5_after_reset", -1);

    // WIDTH=1 sweep, back-to-back
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      e1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("w1 #%0d busy", i), {busy1, done1}, 2'b10);
      @(negedge clk);
      chk($sformatf("w1 #%0d done", i), {busy1, done1}, 2'b01);
      chk($sformatf("w1 #%0d result", i), {cout1, sum1}, e1);
      @(negedge clk);
      chk($sformatf("w1 #%0d idle", i), {busy1, done1}, 2'b00);
    end

    // Randomized against arithmetic reference
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      op8(ra, rb, rc, rexp[7:0], rexp[8], $sformatf("rand%0d", i), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
